// File: rtl/led_matrix_scan_pkg.sv
// Shared constants and types for the LED matrix row scanner.
package led_matrix_scan_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [7:0] OFF_ROW = 8'hFF;

  // One matrix row: active-low red, green and blue column bits.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_row_t;

  localparam rgb_row_t OFF_RGB = '{r: OFF_ROW, g: OFF_ROW, b: OFF_ROW};

  // Bank swap control: idle (accepting traffic) or waiting for frame end.
  typedef enum logic {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/led_matrix_scan_scan_timer.sv
// Row dwell timer: divides CLK into row slots and flags blanking and frame end.
module scan_timer
  import led_matrix_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 5001,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic             clk,
  input  logic             clear,
  output logic [ROW_W-1:0] row_idx,
  output logic             blank_c,
  output logic             frame_end_c
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             dwell_last_c;

  // Decode the counter state into dwell end, blanking window and frame end.
  always_comb begin
    dwell_last_c = (div_cnt == LAST_CNT);
    blank_c      = (div_cnt < BLANK_END);
    frame_end_c  = dwell_last_c && (row_idx == LAST_ROW);
  end

  // Advance the dwell counter and step to the next row when it wraps.
  always_ff @(posedge clk) begin
    if (clear) begin
      div_cnt <= '0;
      row_idx <= '0;
    end else if (dwell_last_c) begin
      div_cnt <= '0;
      row_idx <= row_idx + ROW_W'(1);
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 RGB LED matrix scanner with tear-free frame swaps.
module led_matrix_scan
  import led_matrix_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 5001,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic       commit,
  output logic       wr_ready,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B,
  output logic [2:0] COMM,
  output logic       EN,
  output logic       frame_done
);

  logic [ROW_W-1:0] row_idx;
  logic             blank_c;
  logic             frame_end_c;

  swap_state_t state;
  swap_state_t state_next;
  logic        front_sel;
  logic        back_sel;

  logic accept_wr_c;
  logic accept_commit_c;
  logic swap_c;

  rgb_row_t bank_mem [2][ROWS];
  rgb_row_t front_row_c;
  rgb_row_t wr_data_c;

  scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan_timer (
    .clk         (CLK),
    .clear       (clear),
    .row_idx     (row_idx),
    .blank_c     (blank_c),
    .frame_end_c (frame_end_c)
  );

  assign back_sel = ~front_sel;

  // Swap control state register.
  always_ff @(posedge CLK) begin
    if (clear) begin
      state <= SW_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a commit arms the swap, the frame boundary fires it.
  always_comb begin
    state_next = state;
    case (state)
      SW_IDLE:    if (accept_commit_c) state_next = SW_PENDING;
      SW_PENDING: if (frame_end_c)     state_next = SW_IDLE;
      default:    state_next = SW_IDLE;
    endcase
  end

  // Swap control decodes: traffic is only taken while idle and out of clear.
  always_comb begin
    accept_wr_c     = wr_en  && wr_ready && !clear;
    accept_commit_c = commit && wr_ready && !clear;
    swap_c          = (state == SW_PENDING) && frame_end_c;
  end

  // Ready flag tracks the idle state one edge ahead so it is a flop output.
  always_ff @(posedge CLK) begin
    if (clear) begin
      wr_ready <= 1'b1;
    end else begin
      wr_ready <= (state_next == SW_IDLE);
    end
  end

  // Front bank pointer flips only on the last cycle of row 7.
  always_ff @(posedge CLK) begin
    if (clear) begin
      front_sel <= 1'b0;
    end else if (swap_c) begin
      front_sel <= ~front_sel;
    end
  end

  // Row data paths for the write port and the display read.
  always_comb begin
    wr_data_c   = {wr_r, wr_g, wr_b};
    front_row_c = bank_mem[front_sel][row_idx];
  end

  // Bank storage: clear blanks both banks, writes land in the back bank.
  always_ff @(posedge CLK) begin
    if (clear) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank_mem[b][r] <= OFF_RGB;
        end
      end
    end else if (accept_wr_c) begin
      bank_mem[back_sel][wr_row] <= wr_data_c;
    end
  end

  // Registered pin drive: blank window forces all colours off.
  always_ff @(posedge CLK) begin
    if (clear) begin
      DATA_R     <= OFF_ROW;
      DATA_G     <= OFF_ROW;
      DATA_B     <= OFF_ROW;
      COMM       <= '0;
      EN         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      DATA_R     <= blank_c ? OFF_ROW : front_row_c.r;
      DATA_G     <= blank_c ? OFF_ROW : front_row_c.g;
      DATA_B     <= blank_c ? OFF_ROW : front_row_c.b;
      COMM       <= row_idx;
      EN         <= 1'b1;
      frame_done <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with SCAN_DIV=4, BLANK_CYC=1 (32-cycle frames).
module tb_led_matrix_scan;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLANK_CYC = 1;
  localparam int          FRAME     = 32;
  localparam int          NVEC      = 35;

  logic       CLK = 1'b0;
  logic       clear = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_r = 8'hFF;
  logic [7:0] wr_g = 8'hFF;
  logic [7:0] wr_b = 8'hFF;
  logic       commit = 1'b0;
  logic       wr_ready;
  logic [7:0] DATA_R;
  logic [7:0] DATA_G;
  logic [7:0] DATA_B;
  logic [2:0] COMM;
  logic       EN;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected displayed frame (one 24-bit {r,g,b} word per row).
  logic [23:0] exp_front [8];

  typedef struct {
    logic       clear;
    logic       wr_en;
    logic       commit;
    logic [7:0] exp_data;
    logic [2:0] exp_comm;
    logic       exp_en;
    logic       exp_fd;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [NVEC];

  led_matrix_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .CLK        (CLK),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_r       (wr_r),
    .wr_g       (wr_g),
    .wr_b       (wr_b),
    .commit     (commit),
    .wr_ready   (wr_ready),
    .DATA_R     (DATA_R),
    .DATA_G     (DATA_G),
    .DATA_B     (DATA_B),
    .COMM       (COMM),
    .EN         (EN),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: inputs act at the posedge, outputs sampled at the following negedge.
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_front_ff();
    for (int r = 0; r < 8; r++) exp_front[r] = 24'hFFFFFF;
  endtask

  task automatic check_reset_outs(input string name);
    check({name, " R"},     32'(DATA_R),     32'hFF);
    check({name, " G"},     32'(DATA_G),     32'hFF);
    check({name, " B"},     32'(DATA_B),     32'hFF);
    check({name, " COMM"},  32'(COMM),       32'd0);
    check({name, " EN"},    32'(EN),         32'd0);
    check({name, " fd"},    32'(frame_done), 32'd0);
    check({name, " ready"}, 32'(wr_ready),   32'd1);
  endtask

  // Run one full frame from a frame start. Inputs for cycle 0 are set by the
  // caller; c1_* give the inputs for cycle 1. Each cycle's pins are checked
  // against exp_front: blank first dwell cycle, row data for the other three.
  task automatic run_frame(input string name, input logic c1_wr, input logic [2:0] c1_row,
                           input logic [23:0] c1_rgb, input logic c1_commit,
                           input logic ready_mid, input logic ready_end);
    logic [23:0] exp_rgb;
    int row;
    int sub;
    for (int n = 0; n < FRAME; n++) begin
      cycle();
      if (n == 0) begin
        wr_en  = c1_wr;
        wr_row = c1_row;
        {wr_r, wr_g, wr_b} = c1_rgb;
        commit = c1_commit;
      end else begin
        wr_en  = 1'b0;
        commit = 1'b0;
      end
      row = n / 4;
      sub = n % 4;
      exp_rgb = (sub == 0) ? 24'hFFFFFF : exp_front[row];
      check($sformatf("%s r%0d s%0d COMM", name, row, sub), 32'(COMM), 32'(row));
      check($sformatf("%s r%0d s%0d R", name, row, sub), 32'(DATA_R), 32'(exp_rgb[23:16]));
      check($sformatf("%s r%0d s%0d G", name, row, sub), 32'(DATA_G), 32'(exp_rgb[15:8]));
      check($sformatf("%s r%0d s%0d B", name, row, sub), 32'(DATA_B), 32'(exp_rgb[7:0]));
      check($sformatf("%s r%0d s%0d EN", name, row, sub), 32'(EN), 32'd1);
      check($sformatf("%s r%0d s%0d fd", name, row, sub), 32'(frame_done), 32'(n == FRAME - 1));
      if (n == 15)        check({name, " ready_mid"}, 32'(wr_ready), 32'(ready_mid));
      if (n == FRAME - 1) check({name, " ready_end"}, 32'(wr_ready), 32'(ready_end));
    end
  endtask

  initial begin
    // Reset vectors: 3 clear cycles (one with write+commit that must be ignored),
    // then one full frame of an empty display.
    for (int i = 0; i < NVEC; i++) begin
      if (i < 3) begin
        vecs[i] = '{clear: 1'b1, wr_en: (i == 1), commit: (i == 1), exp_data: 8'hFF,
                    exp_comm: 3'd0, exp_en: 1'b0, exp_fd: 1'b0, exp_ready: 1'b1};
      end else begin
        vecs[i] = '{clear: 1'b0, wr_en: 1'b0, commit: 1'b0, exp_data: 8'hFF,
                    exp_comm: 3'(((i - 3) / 4) % 8), exp_en: 1'b1,
                    exp_fd: (((i - 3) % FRAME) == FRAME - 1), exp_ready: 1'b1};
      end
    end

    for (int i = 0; i < NVEC; i++) begin
      clear  = vecs[i].clear;
      wr_en  = vecs[i].wr_en;
      commit = vecs[i].commit;
      wr_row = 3'd0;
      {wr_r, wr_g, wr_b} = 24'h000000;
      cycle();
      check($sformatf("rst v%0d R", i),     32'(DATA_R),     32'(vecs[i].exp_data));
      check($sformatf("rst v%0d G", i),     32'(DATA_G),     32'(vecs[i].exp_data));
      check($sformatf("rst v%0d B", i),     32'(DATA_B),     32'(vecs[i].exp_data));
      check($sformatf("rst v%0d COMM", i),  32'(COMM),       32'(vecs[i].exp_comm));
      check($sformatf("rst v%0d EN", i),    32'(EN),         32'(vecs[i].exp_en));
      check($sformatf("rst v%0d fd", i),    32'(frame_done), 32'(vecs[i].exp_fd));
      check($sformatf("rst v%0d ready", i), 32'(wr_ready),   32'(vecs[i].exp_ready));
    end
    wr_en  = 1'b0;
    commit = 1'b0;

    // Write row 3 red=E7, then commit; swap lands at the frame boundary.
    set_front_ff();
    wr_en = 1'b1; wr_row = 3'd3; {wr_r, wr_g, wr_b} = 24'hE7FFFF;
    run_frame("wc_old", 1'b0, 3'd0, 24'hFFFFFF, 1'b1, 1'b0, 1'b1);
    exp_front[3] = 24'hE7FFFF;
    run_frame("wc_new", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);

    // Commit, then a write of row 0 = 00 plus a second commit while pending.
    commit = 1'b1;
    run_frame("blk_old", 1'b1, 3'd0, 24'h000000, 1'b1, 1'b0, 1'b1);
    set_front_ff();
    run_frame("blk_swap", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);
    run_frame("blk_once", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);

    // Commit in the frame_done cycle: next frame unchanged, the one after swaps
    // to the stale back bank (row 3 still E7).
    commit = 1'b1;
    run_frame("bnd_hold", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);
    exp_front[3] = 24'hE7FFFF;
    run_frame("bnd_swap", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);

    // Write row 7 green=0F in the same cycle as the commit.
    wr_en = 1'b1; wr_row = 3'd7; {wr_r, wr_g, wr_b} = 24'hFF0FFF; commit = 1'b1;
    run_frame("same_old", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);
    set_front_ff();
    exp_front[7] = 24'hFF0FFF;
    run_frame("same_new", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);

    // Clear while a swap is pending; traffic during clear is ignored.
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    check("clr pending ready", 32'(wr_ready), 32'd0);
    repeat (5) cycle();
    clear = 1'b1;
    wr_en = 1'b1; wr_row = 3'd5; {wr_r, wr_g, wr_b} = 24'h000000; commit = 1'b1;
    cycle();
    wr_en = 1'b0; commit = 1'b0;
    check_reset_outs("clr1");
    cycle();
    clear = 1'b0;
    check_reset_outs("clr2");
    set_front_ff();
    run_frame("post_clr", 1'b0, 3'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
